// File: rtl/f2h_share_sched.sv
// Round-robin scheduler sharing one single-to-half converter among N_REQ requesters.
// A tag register tracks which requester owns the result currently in the converter stage.
module f2h_share_sched #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                 aclk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*32-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          cvt_data,
  output logic                 cvt_en,
  output logic                 cvt_clken,
  input  logic [15:0]          cvt_result,
  input  logic                 cvt_valid,
  output logic                 res_valid,
  output logic [15:0]          res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy,
  output logic                 err_orphan,
  output logic [31:0]          conv_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

  state_t         state_q;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] tag_id_q;
  logic           tag_vld_q;
  logic           flush_done_q;
  logic           err_q;
  logic [31:0]    cnt_q;

  logic           flush_eff;
  logic           gnt_ok;
  logic           gnt_vld;
  logic           gnt;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   sum;

  assign res_valid  = cvt_valid & tag_vld_q;
  assign res_data   = cvt_result;
  assign res_id     = tag_id_q;
  assign cvt_clken  = (~res_valid | res_ready) & ~rst;
  // flush is ignored in the cycle flush_done is being presented
  assign flush_eff  = flush & ~flush_done_q;
  assign gnt_ok     = (state_q != FLUSH) & cvt_clken & ~flush_eff;
  assign gnt        = gnt_ok & gnt_vld;
  assign cvt_en     = gnt;
  assign flush_done = flush_done_q;
  assign busy       = (state_q != IDLE) | tag_vld_q;
  assign err_orphan = err_q;
  assign conv_cnt   = cnt_q;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_q} + k[IDW:0];
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!gnt_vld && req_valid[sum[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    cvt_data  = '0;
    if (gnt) begin
      req_ready[gnt_id] = 1'b1;
      cvt_data          = req_data[{gnt_id, 5'b00000} +: 32];
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= IDW'(N_REQ - 1);
      tag_id_q     <= '0;
      tag_vld_q    <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      flush_done_q <= 1'b0;
      if (cvt_clken) begin
        tag_id_q  <= gnt_id;
        tag_vld_q <= gnt;
      end
      if (gnt) last_q <= gnt_id;
      if (cvt_valid && !tag_vld_q) err_q <= 1'b1;
      if (res_valid && res_ready) cnt_q <= cnt_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (flush_eff)       state_q <= FLUSH;
          else if (|req_valid) state_q <= RUN;
        end
        RUN: begin
          if (flush_eff)
            state_q <= FLUSH;
          else if (!(|req_valid) && !tag_vld_q && !res_valid)
            state_q <= IDLE;
        end
        FLUSH: begin
          if (!tag_vld_q && !res_valid) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
